// File: rtl/mastermind_pkg.sv
// Shared definitions for the Mastermind game controller: FSM state encoding,
// the winning score and the default parameter values.
package mastermind_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        PLAY   = 3'd2,
        GRADE  = 3'd3,
        RESULT = 3'd4,
        WON    = 3'd5,
        LOST   = 3'd6
    } state_t;

    localparam int WIN_ZNARLY         = 4;
    localparam int DEF_MAX_ROUNDS     = 8;
    localparam int DEF_UNITS_PER_GAME = 4;
    localparam int DEF_MAX_GAMES      = 7;

endpackage

// File: rtl/mastermind_edge_pulse.sv
// Rising-edge detector for an already-synchronized level; the pulse is high
// for the single cycle in which the level is 1 and its history is 0.
module mastermind_edge_pulse (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/mastermind_game_ctrl.sv
// Mastermind game controller: coin credit, game/round sequencing and grader handshake.
// Define MASTERMIND_GRADE_TIMEOUT_EN to add a 255-cycle grade timeout with a grade_error pulse.
module mastermind_game_ctrl
    import mastermind_pkg::*;
#(
    parameter int MAX_ROUNDS     = DEF_MAX_ROUNDS,
    parameter int UNITS_PER_GAME = DEF_UNITS_PER_GAME,
    parameter int MAX_GAMES      = DEF_MAX_GAMES
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       coin_inserted,
    input  logic [1:0] coin_value,
    input  logic       start_game,
    input  logic       grade_it,
    input  logic       grade_done,
    input  logic [3:0] znarly_in,
    input  logic [3:0] zood_in,
    output logic       grade_start,
    output logic       load_num_games,
    output logic       load_guess,
    output logic       load_znarly_zood,
    output logic       clear_game,
    output logic       display_master,
    output logic       game_won,
    output logic [3:0] num_games,
    output logic [3:0] round,
    output logic [2:0] state_dbg
`ifdef MASTERMIND_GRADE_TIMEOUT_EN
    ,
    output logic       grade_error
`endif
);

    // Grader handshake: grade_start is a one-cycle request issued on entry to
    // GRADE; the grader answers with a one-cycle grade_done whose znarly/zood
    // are valid in that same cycle. grade_done is only honoured inside GRADE.

    state_t     state, state_d;
    logic [4:0] units, units_d, unit_sum;
    logic [3:0] num_games_d, round_d, znarly_q, znarly_d;
    logic       grade_start_d, load_num_games_d, load_guess_d, load_zz_d;
    logic       clear_game_d, display_master_d, game_won_d;
    logic       coin_edge, start_edge, grade_edge;
    logic       coin_ok, credit, debit;
    logic       unused_zood;
`ifdef MASTERMIND_GRADE_TIMEOUT_EN
    logic [7:0] timer, timer_d;
    logic       grade_error_d;
`endif

    assign unused_zood = ^zood_in;
    assign state_dbg   = state;

    mastermind_edge_pulse u_coin_edge (
        .CLOCK_50 (CLOCK_50), .reset (reset), .level (coin_inserted), .pulse (coin_edge)
    );
    mastermind_edge_pulse u_start_edge (
        .CLOCK_50 (CLOCK_50), .reset (reset), .level (start_game), .pulse (start_edge)
    );
    mastermind_edge_pulse u_grade_edge (
        .CLOCK_50 (CLOCK_50), .reset (reset), .level (grade_it), .pulse (grade_edge)
    );

    always_comb begin
        state_d          = state;
        units_d          = units;
        round_d          = round;
        znarly_d         = znarly_q;
        grade_start_d    = 1'b0;
        load_guess_d     = 1'b0;
        load_zz_d        = 1'b0;
        clear_game_d     = 1'b0;
        display_master_d = display_master;
        game_won_d       = game_won;
        debit            = 1'b0;
`ifdef MASTERMIND_GRADE_TIMEOUT_EN
        timer_d          = 8'd0;
        grade_error_d    = 1'b0;
`endif
        unit_sum = units + {3'b000, coin_value};
        coin_ok  = coin_edge && (coin_value != 2'b00) && (num_games != 4'(MAX_GAMES));
        credit   = coin_ok && (unit_sum >= 5'(UNITS_PER_GAME));

        case (state)
            IDLE: begin
                if (start_edge && (num_games != 4'd0)) debit = 1'b1;
            end
            CLEAR: state_d = PLAY;
            PLAY: begin
                if (grade_edge) begin
                    state_d       = GRADE;
                    load_guess_d  = 1'b1;
                    grade_start_d = 1'b1;
                end
            end
            GRADE: begin
                if (grade_done) begin
                    state_d   = RESULT;
                    znarly_d  = znarly_in;
                    load_zz_d = 1'b1;
                end
`ifdef MASTERMIND_GRADE_TIMEOUT_EN
                else if (timer == 8'd254) begin
                    state_d       = PLAY;
                    grade_error_d = 1'b1;
                end else begin
                    timer_d = timer + 8'd1;
                end
`endif
            end
            RESULT: begin
                if (znarly_q == 4'(WIN_ZNARLY)) begin
                    state_d          = WON;
                    game_won_d       = 1'b1;
                    display_master_d = 1'b1;
                end else if (round == 4'(MAX_ROUNDS)) begin
                    state_d          = LOST;
                    game_won_d       = 1'b0;
                    display_master_d = 1'b1;
                end else begin
                    state_d = PLAY;
                    round_d = round + 4'd1;
                end
            end
            WON, LOST: begin
                if (start_edge) begin
                    if (num_games != 4'd0) debit = 1'b1;
                    else                   state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Starting a game spends one credit; a coin landing in the same cycle nets out.
        if (debit) begin
            state_d          = CLEAR;
            round_d          = 4'd1;
            clear_game_d     = 1'b1;
            display_master_d = 1'b0;
            game_won_d       = 1'b0;
        end
        if (coin_ok) units_d = credit ? unit_sum - 5'(UNITS_PER_GAME) : unit_sum;
        num_games_d      = num_games + {3'b000, credit} - {3'b000, debit};
        load_num_games_d = credit | debit;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            units            <= 5'd0;
            num_games        <= 4'd0;
            round            <= 4'd0;
            znarly_q         <= 4'd0;
            grade_start      <= 1'b0;
            load_num_games   <= 1'b0;
            load_guess       <= 1'b0;
            load_znarly_zood <= 1'b0;
            clear_game       <= 1'b0;
            display_master   <= 1'b0;
            game_won         <= 1'b0;
        end else begin
            state            <= state_d;
            units            <= units_d;
            num_games        <= num_games_d;
            round            <= round_d;
            znarly_q         <= znarly_d;
            grade_start      <= grade_start_d;
            load_num_games   <= load_num_games_d;
            load_guess       <= load_guess_d;
            load_znarly_zood <= load_zz_d;
            clear_game       <= clear_game_d;
            display_master   <= display_master_d;
            game_won         <= game_won_d;
        end
    end

`ifdef MASTERMIND_GRADE_TIMEOUT_EN
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            timer       <= 8'd0;
            grade_error <= 1'b0;
        end else begin
            timer       <= timer_d;
            grade_error <= grade_error_d;
        end
    end
`endif

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Self-checking bench for mastermind_game_ctrl: behavioural model with an expected-output
// queue compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mastermind_game_ctrl;

    localparam int MAX_ROUNDS = 8;
    localparam int UPG        = 4;
    localparam int MAX_GAMES  = 7;
    localparam int W          = 16;
`ifdef MASTERMIND_GRADE_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_CLEAR = 1, M_PLAY = 2, M_GRADE = 3, M_RESULT = 4, M_OVER = 5;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       coin_inserted = 1'b0;
    logic [1:0] coin_value = 2'b00;
    logic       start_game = 1'b0;
    logic       grade_it = 1'b0;
    logic       grade_done = 1'b0;
    logic [3:0] znarly_in = 4'd0;
    logic [3:0] zood_in = 4'd0;
    logic       grade_start, load_num_games, load_guess, load_znarly_zood, clear_game;
    logic       display_master, game_won;
    logic [3:0] num_games, round;
    logic [2:0] state_dbg_unused;
    logic       gerr_w;
`ifdef MASTERMIND_GRADE_TIMEOUT_EN
    logic       grade_error;
    assign gerr_w = grade_error;
`else
    assign gerr_w = 1'b0;
`endif

    mastermind_game_ctrl #(
        .MAX_ROUNDS     (MAX_ROUNDS),
        .UNITS_PER_GAME (UPG),
        .MAX_GAMES      (MAX_GAMES)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .coin_inserted    (coin_inserted),
        .coin_value       (coin_value),
        .start_game       (start_game),
        .grade_it         (grade_it),
        .grade_done       (grade_done),
        .znarly_in        (znarly_in),
        .zood_in          (zood_in),
        .grade_start      (grade_start),
        .load_num_games   (load_num_games),
        .load_guess       (load_guess),
        .load_znarly_zood (load_znarly_zood),
        .clear_game       (clear_game),
        .display_master   (display_master),
        .game_won         (game_won),
        .num_games        (num_games),
        .round            (round),
        .state_dbg        (state_dbg_unused)
`ifdef MASTERMIND_GRADE_TIMEOUT_EN
        ,
        .grade_error      (grade_error)
`endif
    );

    // ---------------- clock ----------------
    always #5 CLOCK_50 = ~CLOCK_50;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] dut_vec;
    logic [W-1:0] cmp_exp;

    assign dut_vec = {gerr_w, grade_start, load_num_games, load_guess, load_znarly_zood,
                      clear_game, display_master, game_won, num_games, round};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_phase, m_games, m_units, m_round, m_score, m_wait, m_gained, m_total;
    bit m_disp, m_won, m_gs, m_lng, m_lg, m_lzz, m_clr, m_gerr;
    bit m_prev_coin, m_prev_start, m_prev_grade, m_ce, m_se, m_ge, m_spend;

    function automatic logic [W-1:0] pack_model();
        return {m_gerr, m_gs, m_lng, m_lg, m_lzz, m_clr, m_disp, m_won,
                4'(m_games), 4'(m_round)};
    endfunction

    always @(posedge CLOCK_50) begin
        if (reset) begin
            m_phase = M_IDLE; m_games = 0; m_units = 0; m_round = 0; m_score = 0; m_wait = 0;
            m_disp = 0; m_won = 0; m_gs = 0; m_lng = 0; m_lg = 0; m_lzz = 0; m_clr = 0; m_gerr = 0;
            m_prev_coin = 0; m_prev_start = 0; m_prev_grade = 0;
            exp_q.delete();
        end else begin
            m_ce = coin_inserted && !m_prev_coin;
            m_se = start_game && !m_prev_start;
            m_ge = grade_it && !m_prev_grade;
            m_prev_coin = coin_inserted; m_prev_start = start_game; m_prev_grade = grade_it;
            m_gs = 0; m_lg = 0; m_lzz = 0; m_clr = 0; m_gerr = 0;
            m_gained = 0; m_spend = 0;

            if (m_phase == M_IDLE) begin
                m_spend = m_se && (m_games > 0);
            end else if (m_phase == M_CLEAR) begin
                m_phase = M_PLAY;
            end else if (m_phase == M_PLAY) begin
                if (m_ge) begin m_phase = M_GRADE; m_lg = 1; m_gs = 1; m_wait = 0; end
            end else if (m_phase == M_GRADE) begin
                if (grade_done) begin
                    m_score = int'(znarly_in); m_lzz = 1; m_phase = M_RESULT;
                end else begin
                    m_wait++;
                    if (TIMEOUT_EN && m_wait == 255) begin m_phase = M_PLAY; m_gerr = 1; end
                end
            end else if (m_phase == M_RESULT) begin
                if (m_score == 4)                begin m_phase = M_OVER; m_won = 1; m_disp = 1; end
                else if (m_round == MAX_ROUNDS)  begin m_phase = M_OVER; m_won = 0; m_disp = 1; end
                else                             begin m_phase = M_PLAY; m_round++; end
            end else begin
                if (m_se) begin
                    if (m_games > 0) m_spend = 1;
                    else             m_phase = M_IDLE;
                end
            end

            if (m_ce && coin_value != 2'b00 && m_games < MAX_GAMES) begin
                m_total  = m_units + int'(coin_value);
                m_gained = m_total / UPG;
                m_units  = m_total % UPG;
            end
            if (m_spend) begin
                m_phase = M_CLEAR; m_round = 1; m_clr = 1; m_disp = 0; m_won = 0;
            end
            m_games = m_games + m_gained - (m_spend ? 1 : 0);
            m_lng   = (m_gained > 0) || m_spend;
            exp_q.push_back(pack_model());
        end
    end

    always @(negedge CLOCK_50) begin
        if (!reset && exp_q.size() > 0) begin
            cmp_exp = exp_q.pop_front();
            check("outputs", int'(dut_vec), int'(cmp_exp));
        end
    end

    // ---------------- strobe monitor ----------------
    int cnt_lng, cnt_clr, cnt_lg, cnt_both, cnt_lzz, cyc, cyc_gs, cyc_gerr;
    bit gerr_seen;

    always @(negedge CLOCK_50) begin
        cyc++;
        if (!reset) begin
            cnt_lng  += int'(load_num_games);
            cnt_clr  += int'(clear_game);
            cnt_lg   += int'(load_guess);
            cnt_both += int'(load_guess && grade_start);
            cnt_lzz  += int'(load_znarly_zood);
            if (grade_start) cyc_gs = cyc;
            if (gerr_w) begin gerr_seen = 1; cyc_gerr = cyc; end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic clear_counts();
        cnt_lng = 0; cnt_clr = 0; cnt_lg = 0; cnt_both = 0; cnt_lzz = 0; gerr_seen = 0;
    endtask

    task automatic coin(input int v);
        coin_value = 2'(v); coin_inserted = 1'b1; tick();
        coin_inserted = 1'b0; tick();
    endtask

    task automatic press_start();
        start_game = 1'b1; tick();
        start_game = 1'b0; tick();
    endtask

    task automatic press_grade();
        grade_it = 1'b1; tick();
        grade_it = 1'b0; tick();
    endtask

    task automatic grade_result(input int z, input int zo);
        znarly_in = 4'(z); zood_in = 4'(zo); grade_done = 1'b1; tick();
        grade_done = 1'b0; tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clear_counts();
        repeat (3) @(posedge CLOCK_50);
        tick();
        check("reset_outputs", int'(dut_vec), 0);
        reset = 1'b0;
        tick(); tick();

        // Coins 3 + 2 buy one game and leave one unit behind.
        clear_counts();
        coin(3); coin(2); tick();
        check("coin_games", int'(num_games), 1);
        check("coin_lng_pulses", cnt_lng, 1);

        // One-guess win.
        clear_counts();
        press_start(); tick();
        check("start_clear_pulse", cnt_clr, 1);
        check("start_games", int'(num_games), 0);
        check("start_round", int'(round), 1);
        press_grade(); tick();
        check("guess_load_and_start", cnt_both, 1);
        grade_result(4, 0); tick();
        check("win_lzz_pulse", cnt_lzz, 1);
        check("win_game_won", int'(game_won), 1);
        check("win_display", int'(display_master), 1);
        check("win_games", int'(num_games), 0);
        check("win_lng_pulses", cnt_lng, 1);

        // Leftover unit plus a 3-unit coin makes a credit.
        coin(3); tick();
        check("units_carry", int'(num_games), 1);

        // Eight misses lose the game.
        press_start(); tick();
        check("restart_cleared", int'({display_master, game_won}), 0);
        for (int i = 0; i < 8; i++) begin
            press_grade();
            grade_result(2, 1); tick();
            if (i < 7) check("round_advance", int'(round), i + 2);
        end
        check("lost_round", int'(round), 8);
        check("lost_display", int'(display_master), 1);
        check("lost_game_won", int'(game_won), 0);

        // Idle with no credit: start does nothing.
        clear_counts();
        press_start(); press_start(); tick();
        check("no_credit_clear", cnt_clr, 0);
        check("no_credit_lng", cnt_lng, 0);

        // Start and a completing coin in the same cycle net to zero change.
        coin(3); coin(1); coin(3);
        clear_counts();
        coin_value = 2'd1; coin_inserted = 1'b1; start_game = 1'b1; tick();
        coin_inserted = 1'b0; start_game = 1'b0; tick(); tick();
        check("net_games", int'(num_games), 1);
        check("net_lng_pulses", cnt_lng, 1);
        check("net_clear", cnt_clr, 1);

        // Saturation at MAX_GAMES discards the coin without touching the units.
        repeat (6) begin coin(3); coin(1); end
        check("sat_full", int'(num_games), 7);
        coin(3); tick();
        check("sat_hold", int'(num_games), 7);
        press_grade(); grade_result(4, 4); tick();
        press_start(); tick();
        check("sat_spend", int'(num_games), 6);
        coin(1); tick();
        check("sat_units_unchanged", int'(num_games), 6);

        // Reset in GRADE abandons the grade; a late grade_done is ignored.
        press_grade();
        reset = 1'b1; #1;
        check("async_reset", int'(dut_vec), 0);
        tick(); tick();
        reset = 1'b0; tick();
        clear_counts();
        grade_result(4, 0); tick(); tick();
        check("post_reset_idle", int'(dut_vec), 0);
        check("post_reset_lzz", cnt_lzz, 0);

`ifdef MASTERMIND_GRADE_TIMEOUT_EN
        coin(3); coin(1); press_start(); tick();
        clear_counts();
        press_grade();
        for (int k = 0; k < 300 && !gerr_seen; k++) tick();
        check("timeout_seen", int'(gerr_seen), 1);
        check("timeout_latency", cyc_gerr - cyc_gs, 255);
        check("timeout_round", int'(round), 1);
        reset = 1'b1; tick(); reset = 1'b0; tick();
`endif

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) coin_inserted = ~coin_inserted;
            coin_value = 2'($urandom_range(3));
            if ($urandom_range(3) == 0) start_game = ~start_game;
            if ($urandom_range(3) == 0) grade_it = ~grade_it;
            grade_done = ($urandom_range(5) == 0);
            znarly_in  = ($urandom_range(4) == 0) ? 4'd4 : 4'($urandom_range(3));
            zood_in    = 4'($urandom_range(15));
            reset      = (c >= 1500 && c < 1503);
            tick();
        end
        coin_inserted = 1'b0; start_game = 1'b0; grade_it = 1'b0; grade_done = 1'b0; reset = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
